// File: rtl/alu_seq.sv
// Registered ALU with add/sub/logic ops, Z/N/C/V flags and a start/busy/done handshake.
// Define ALU_MUL_EN to build the multi-cycle shift-add multiplier for op 111; otherwise op 111 is a NOP.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             out_en,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] bus_out,
  output logic [3:0]       flags,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_ADC = 3'b010;
  localparam logic [2:0] OP_SBC = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic {S_IDLE, S_MUL} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] addB, aluRes;
  logic             addCin;
  logic [WIDTH:0]   addSum;
  logic [3:0]       aluFlags;

`ifdef ALU_MUL_EN
  localparam int CW = $clog2(WIDTH) + 1;
  logic [2*WIDTH-1:0] mcand_q, mcand_d, acc_q, acc_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;
`endif

  // Single-cycle datapath; SUB/SBC feed ~b so the carry-out means "no borrow".
  always_comb begin
    addB     = b;
    addCin   = 1'b0;
    aluRes   = '0;
    aluFlags = '0;
    case (op)
      OP_SUB:  begin addB = ~b; addCin = 1'b1; end
      OP_ADC:  addCin = flags_q[2];
      OP_SBC:  begin addB = ~b; addCin = flags_q[2]; end
      default: ;
    endcase
    addSum = {1'b0, a} + {1'b0, addB} + {{WIDTH{1'b0}}, addCin};
    if (op[2]) begin
      case (op[1:0])
        2'b00:   aluRes = a & b;
        2'b01:   aluRes = a | b;
        default: aluRes = a ^ b;
      endcase
      aluFlags = {2'b00, aluRes[WIDTH-1], aluRes == '0};
    end else begin
      aluRes   = addSum[WIDTH-1:0];
      aluFlags = {(a[WIDTH-1] == addB[WIDTH-1]) && (addSum[WIDTH-1] != a[WIDTH-1]),
                  addSum[WIDTH], addSum[WIDTH-1], addSum[WIDTH-1:0] == '0};
    end
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    flags_d  = flags_q;
    done_d   = 1'b0;
`ifdef ALU_MUL_EN
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op == OP_MUL) begin
`ifdef ALU_MUL_EN
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = S_MUL;
`else
            done_d   = 1'b1;
`endif
          end else begin
            result_d = aluRes;
            flags_d  = aluFlags;
            done_d   = 1'b1;
          end
        end
      end
      S_MUL: begin
`ifdef ALU_MUL_EN
        // The final step's partial sum is committed on the same edge it is formed.
        acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          result_d = acc_d[WIDTH-1:0];
          flags_d  = {1'b0, |acc_d[2*WIDTH-1:WIDTH], acc_d[WIDTH-1], acc_d[WIDTH-1:0] == '0};
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end
`else
        state_d = S_IDLE;
`endif
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
`ifdef ALU_MUL_EN
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
`ifdef ALU_MUL_EN
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign result  = result_q;
  assign flags   = flags_q;
  assign done    = done_q;
  assign busy    = (state_q == S_MUL);
  assign bus_out = out_en ? result_q : '0;

endmodule
